// File: rtl/seg7_mux_driver_pkg.sv
// rtl/seg7_mux_driver_pkg.sv - shared types and segment constants for the 7-segment driver
package seg7_mux_driver_pkg;
`include "seg7_defs.vh"

    localparam int NUM_DIGITS = 4;

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;

endpackage

// File: rtl/seg7_defs.vh
// rtl/seg7_defs.vh - active-low segment codes and blanking constants for 7-segment displays
`ifndef SEG7_DEFS_VH
`define SEG7_DEFS_VH
localparam logic [7:0] SEG_0   = 8'hC0;
localparam logic [7:0] SEG_1   = 8'hF9;
localparam logic [7:0] SEG_2   = 8'hA4;
localparam logic [7:0] SEG_3   = 8'hB0;
localparam logic [7:0] SEG_4   = 8'h99;
localparam logic [7:0] SEG_5   = 8'h92;
localparam logic [7:0] SEG_6   = 8'h82;
localparam logic [7:0] SEG_7   = 8'hF8;
localparam logic [7:0] SEG_8   = 8'h80;
localparam logic [7:0] SEG_9   = 8'h90;
localparam logic [7:0] SEG_A   = 8'h88;
localparam logic [7:0] SEG_B   = 8'h83;
localparam logic [7:0] SEG_C   = 8'hC6;
localparam logic [7:0] SEG_D   = 8'hA1;
localparam logic [7:0] SEG_E   = 8'h86;
localparam logic [7:0] SEG_F   = 8'h8E;
localparam logic [7:0] SEG_OFF = 8'hFF;
localparam logic [3:0] AN_OFF  = 4'hF;
`endif

// File: rtl/seg7_mux_driver_hex_to_sseg.sv
// rtl/seg7_mux_driver_hex_to_sseg.sv - hex nibble to active-low g..a segment decoder
module hex_to_sseg
    import seg7_mux_driver_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] sseg
);

    always_comb begin
        sseg = SEG_OFF[6:0];
        case (hex)
            4'h0: sseg = SEG_0[6:0];
            4'h1: sseg = SEG_1[6:0];
            4'h2: sseg = SEG_2[6:0];
            4'h3: sseg = SEG_3[6:0];
            4'h4: sseg = SEG_4[6:0];
            4'h5: sseg = SEG_5[6:0];
            4'h6: sseg = SEG_6[6:0];
            4'h7: sseg = SEG_7[6:0];
            4'h8: sseg = SEG_8[6:0];
            4'h9: sseg = SEG_9[6:0];
            4'hA: sseg = SEG_A[6:0];
            4'hB: sseg = SEG_B[6:0];
            4'hC: sseg = SEG_C[6:0];
            4'hD: sseg = SEG_D[6:0];
            4'hE: sseg = SEG_E[6:0];
            4'hF: sseg = SEG_F[6:0];
            default: sseg = SEG_OFF[6:0];
        endcase
    end

endmodule

// File: rtl/seg7_mux_driver.sv
// rtl/seg7_mux_driver.sv - 4-digit multiplexed 7-segment driver with frame-aligned double buffering
module seg7_mux_driver
    import seg7_mux_driver_pkg::*;
#(
    parameter int N = 18
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] hex_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [3:0]  an,
    output logic [7:0]  sseg,
    output logic        frame_done
);

    logic [N-1:0] presc;
    logic [1:0]   idx;
    disp_t        active;
    disp_t        shadow;
    logic         pending;
    logic         tick;
    logic         accept;
    logic         commit;
    logic [3:0]   cur_nib;
    logic [6:0]   seg_code;

    assign tick       = &presc;
    assign load_ready = ~pending;
    assign accept     = load_valid && !pending;
    // Commit only on the last slot so the next frame starts entirely on new content.
    assign commit     = tick && (idx == 2'd3) && pending;
    assign cur_nib    = active.hex[{idx, 2'b00} +: 4];

    hex_to_sseg u_dec (
        .hex  (cur_nib),
        .sseg (seg_code)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc      <= '0;
            idx        <= 2'd0;
            an         <= AN_OFF;
            sseg       <= SEG_OFF;
            active     <= '{hex: 16'h0000, dp: 4'h0, blank: 4'hF};
            shadow     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            presc      <= presc + 1'b1;
            frame_done <= tick && (idx == 2'd3);
            if (tick) begin
                idx <= idx + 2'd1;
                if (active.blank[idx]) begin
                    an   <= AN_OFF;
                    sseg <= SEG_OFF;
                end else begin
                    an   <= ~(4'b0001 << idx);
                    sseg <= {~active.dp[idx], seg_code};
                end
            end
            // accept and commit are exclusive: commit needs pending, accept needs !pending.
            if (commit) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (accept) begin
                shadow  <= '{hex: hex_in, dp: dp_in, blank: blank_in};
                pending <= 1'b1;
            end
        end
    end

endmodule
